// File: rtl/grid_pkg.sv
// ---------------------------------------------------------------------------
// grid_pkg -- shared constants for the grid fire controller.
//   * 2-bit cell codes (water / ship / miss / hit)
//   * 2-bit game FSM state encodings
//   * shot counter width
//   * shot_cell(): the code a cell takes when it is fired upon
// ---------------------------------------------------------------------------
package grid_pkg;

  // Cell codes
  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  // Game FSM states
  localparam logic [1:0] ST_SETUP = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_WON   = 2'b10;
  localparam logic [1:0] ST_LOST  = 2'b11;

  // Shot counter width (saturates at all-ones)
  localparam int SHOT_W = 8;

  // A fired-upon cell: ship becomes hit, water becomes miss, and cells that
  // were already shot keep their code.
  function automatic logic [1:0] shot_cell(input logic [1:0] code);
    case (code)
      CELL_SHIP:  shot_cell = CELL_HIT;
      CELL_WATER: shot_cell = CELL_MISS;
      default:    shot_cell = code;
    endcase
  endfunction

endpackage

// File: rtl/sel_onehot_check.sv
// ---------------------------------------------------------------------------
// sel_onehot_check -- registered "select is not one-hot" flag.
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   sel    in   GRID_N row/column select switches
//   error  out  1 one cycle after sel has zero or several bits set
// ---------------------------------------------------------------------------
module sel_onehot_check #(
  parameter int GRID_N = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_N-1:0] sel,
  output logic              error
);

  logic sel_onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) error <= 1'b0;
    else        error <= !sel_onehot;
  end

endmodule

// File: rtl/grid_fire_ctrl.sv
// ---------------------------------------------------------------------------
// grid_fire_ctrl -- battleship-style grid game controller.
//
// A GRID_N x GRID_N board is loaded with ships in SETUP, then in PLAY each
// rising edge of fire shoots a whole row (n_row=0) or column (n_row=1) picked
// by the one-hot sel switches. The game is WON when no ship cells remain.
//
// Ports
//   clk, reset     clock, asynchronous active-low reset
//   sel            one-hot row/column select
//   n_row          0 = sel picks a row, 1 = a column
//   fire           debounced fire level (rising edge fires a shot)
//   start          start game / return to setup after WON or LOST
//   load_en/idx/ship  setup write of one cell (1 = ship, 0 = water)
//   display_state  2 bits per cell, cell k at [2k+1:2k], k = row*GRID_N+col
//   error          registered "sel not one-hot"; blocks shots while high
//   hit_pulse      one-cycle pulse when a shot hits at least one ship
//   shots          shots fired (saturating)
//   ships_left     ship cells not yet hit
//   game_state     SETUP / PLAY / WON / LOST
//
// Build option
//   SHOT_LIMIT_EN  when defined, PLAY moves to LOST once shots reaches
//                  SHOTS_MAX with ships remaining; otherwise LOST is never
//                  entered and shots only saturates.
// ---------------------------------------------------------------------------
module grid_fire_ctrl
  import grid_pkg::*;
#(
  parameter int GRID_N    = 4,
  parameter int SHOTS_MAX = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [GRID_N-1:0]                      sel,
  input  logic                                   n_row,
  input  logic                                   fire,
  input  logic                                   start,
  input  logic                                   load_en,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]       load_idx,
  input  logic                                   load_ship,
  output logic [2*GRID_N*GRID_N-1:0]             display_state,
  output logic                                   error,
  output logic                                   hit_pulse,
  output logic [SHOT_W-1:0]                      shots,
  output logic [$clog2(GRID_N*GRID_N+1)-1:0]     ships_left,
  output logic [1:0]                             game_state
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int CNT_W = $clog2(CELLS + 1);

`ifdef SHOT_LIMIT_EN
  localparam bit SHOT_LIMIT = 1'b1;
`else
  localparam bit SHOT_LIMIT = 1'b0;
`endif

  logic [1:0]       cells [CELLS];
  logic             fire_q;
  logic             shot_fire;
  logic             idx_ok;
  logic [CELLS-1:0] in_line;
  logic [CNT_W-1:0] hit_cnt;

  sel_onehot_check #(.GRID_N(GRID_N)) u_sel_check (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .error (error)
  );

  // A shot needs a fresh fire edge, a settled one-hot select and PLAY.
  assign shot_fire = (game_state == ST_PLAY) && fire && !fire_q && !error;
  assign idx_ok    = int'(load_idx) < CELLS;

  // Cells covered by the selected line and how many of them are ships.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    in_line = '0;
    hit_cnt = '0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        in_line[r*GRID_N+c] = n_row ? sel[c] : sel[r];
      end
    end
    for (int k = 0; k < CELLS; k++) begin
      if (in_line[k] && cells[k] == CELL_SHIP) hit_cnt = hit_cnt + CNT_W'(1);
    end
  end

  // During PLAY ships are hidden so the board only reveals shot results.
  always_comb begin
    display_state = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (game_state == ST_PLAY && cells[k] == CELL_SHIP)
        display_state[2*k +: 2] = CELL_WATER;
      else
        display_state[2*k +: 2] = cells[k];
    end
  end

  // NOTE: the cell array is small and the game relies on an all-water board
  // after reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CELLS; k++) cells[k] <= CELL_WATER;
      game_state <= ST_SETUP;
      shots      <= '0;
      ships_left <= '0;
      hit_pulse  <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      fire_q    <= fire;
      hit_pulse <= 1'b0;

      case (game_state)
        ST_SETUP: begin
          if (load_en && idx_ok) begin
            cells[load_idx] <= load_ship ? CELL_SHIP : CELL_WATER;
            if (load_ship && cells[load_idx] == CELL_WATER)
              ships_left <= ships_left + CNT_W'(1);
            else if (!load_ship && cells[load_idx] == CELL_SHIP)
              ships_left <= ships_left - CNT_W'(1);
          end
          // start judges the ship count from before any same-cycle load.
          if (start && ships_left != '0) game_state <= ST_PLAY;
        end

        ST_PLAY: begin
          // Win is checked first so a final hit on the last allowed shot wins.
          if (ships_left == '0)
            game_state <= ST_WON;
          else if (SHOT_LIMIT && shots >= SHOT_W'(SHOTS_MAX))
            game_state <= ST_LOST;

          if (shot_fire) begin
            for (int k = 0; k < CELLS; k++) begin
              if (in_line[k]) cells[k] <= shot_cell(cells[k]);
            end
            if (shots != '1) shots <= shots + SHOT_W'(1);
            ships_left <= ships_left - hit_cnt;
            hit_pulse  <= (hit_cnt != '0);
          end
        end

        default: begin // ST_WON, ST_LOST
          if (start) begin
            for (int k = 0; k < CELLS; k++) cells[k] <= CELL_WATER;
            shots      <= '0;
            ships_left <= '0;
            game_state <= ST_SETUP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_fire_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grid_fire_ctrl -- directed scoreboard bench for grid_fire_ctrl
// (GRID_N=4, SHOTS_MAX=2). Stimulus pushes the expected board snapshot after
// each step; a monitor pops it on the following falling edge and compares.
// ---------------------------------------------------------------------------
module tb_grid_fire_ctrl;

  localparam int GRID_N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sel;
  logic        n_row, fire, start, load_en, load_ship;
  logic [3:0]  load_idx;
  logic [31:0] display_state;
  logic        error, hit_pulse;
  logic [7:0]  shots;
  logic [4:0]  ships_left;
  logic [1:0]  game_state;

  grid_fire_ctrl #(.GRID_N(GRID_N), .SHOTS_MAX(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .sel           (sel),
    .n_row         (n_row),
    .fire          (fire),
    .start         (start),
    .load_en       (load_en),
    .load_idx      (load_idx),
    .load_ship     (load_ship),
    .display_state (display_state),
    .error         (error),
    .hit_pulse     (hit_pulse),
    .shots         (shots),
    .ships_left    (ships_left),
    .game_state    (game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] disp;
    logic [7:0]  shots;
    logic [4:0]  ships;
    logic [1:0]  st;
    logic        err;
    logic        hit;
  } snap_t;

  snap_t snap_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    hits_seen   = 0;
  int    hits_exp    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_snap(input string nm, input logic [31:0] d, input logic [7:0] sh,
                             input logic [4:0] sl, input logic [1:0] st,
                             input logic er, input logic hp);
    snap_t s;
    s.name = nm; s.disp = d; s.shots = sh; s.ships = sl; s.st = st; s.err = er; s.hit = hp;
    snap_q.push_back(s);
  endtask

  // Monitor: counts every hit pulse and checks any pending snapshot.
  initial begin
    forever begin
      @(negedge clk);
      if (hit_pulse === 1'b1) hits_seen++;
      if (snap_q.size() > 0) begin
        snap_t s;
        s = snap_q.pop_front();
        check({s.name, ".disp"},  display_state,    s.disp);
        check({s.name, ".shots"}, 32'(shots),       32'(s.shots));
        check({s.name, ".ships"}, 32'(ships_left),  32'(s.ships));
        check({s.name, ".state"}, 32'(game_state),  32'(s.st));
        check({s.name, ".error"}, 32'(error),       32'(s.err));
        check({s.name, ".hit"},   32'(hit_pulse),   32'(s.hit));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] idx, input logic ship);
    load_en = 1'b1; load_idx = idx; load_ship = ship;
    step();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sel = 4'b0001; n_row = 1'b0; fire = 1'b0; start = 1'b0;
    load_en = 1'b0; load_idx = '0; load_ship = 1'b0;
    expect_snap("reset", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    step(); step();
    reset = 1'b1;
    step();

    // Setup loads: add, duplicate add, add then remove.
    load(4'd5, 1'b1);
    expect_snap("load5", 32'h0000_0400, 8'd0, 5'd1, 2'b00, 1'b0, 1'b0);
    load(4'd5, 1'b1);
    expect_snap("load5_again", 32'h0000_0400, 8'd0, 5'd1, 2'b00, 1'b0, 1'b0);
    load(4'd6, 1'b1);
    expect_snap("load6", 32'h0000_1400, 8'd0, 5'd2, 2'b00, 1'b0, 1'b0);
    load(4'd6, 1'b0);
    expect_snap("unload6", 32'h0000_0400, 8'd0, 5'd1, 2'b00, 1'b0, 1'b0);

    // Start into PLAY: ship hidden.
    pulse_start();
    expect_snap("play", 32'h0, 8'd0, 5'd1, 2'b01, 1'b0, 1'b0);
    pulse_start();
    expect_snap("start_in_play", 32'h0, 8'd0, 5'd1, 2'b01, 1'b0, 1'b0);
    load(4'd5, 1'b0);
    expect_snap("load_in_play", 32'h0, 8'd0, 5'd1, 2'b01, 1'b0, 1'b0);

    // Non-one-hot select blocks the shot.
    sel = 4'b0011;
    step();
    expect_snap("sel_err", 32'h0, 8'd0, 5'd1, 2'b01, 1'b1, 1'b0);
    fire = 1'b1;
    step();
    expect_snap("fire_err", 32'h0, 8'd0, 5'd1, 2'b01, 1'b1, 1'b0);
    fire = 1'b0; sel = 4'b0001;
    step();
    expect_snap("sel_ok", 32'h0, 8'd0, 5'd1, 2'b01, 1'b0, 1'b0);

    // Fire held for 10 cycles on row 0: exactly one miss shot.
    fire = 1'b1;
    step();
    expect_snap("row0_miss", 32'h0000_00AA, 8'd1, 5'd1, 2'b01, 1'b0, 1'b0);
    repeat (9) step();
    expect_snap("fire_held", 32'h0000_00AA, 8'd1, 5'd1, 2'b01, 1'b0, 1'b0);
    fire = 1'b0;
    step();

    // Row 1 hits the ship at cell 5.
    sel = 4'b0010;
    fire = 1'b1;
    step();
    hits_exp++;
    expect_snap("row1_hit", 32'h0000_AEAA, 8'd2, 5'd0, 2'b01, 1'b0, 1'b1);
    fire = 1'b0;
    step();
    expect_snap("won", 32'h0000_AEAA, 8'd2, 5'd0, 2'b10, 1'b0, 1'b0);
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
    expect_snap("fire_in_won", 32'h0000_AEAA, 8'd2, 5'd0, 2'b10, 1'b0, 1'b0);

    // Restart, empty-board start ignored, then a column shot.
    pulse_start();
    expect_snap("restart", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    pulse_start();
    expect_snap("start_empty", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    load(4'd9, 1'b1);
    pulse_start();
    expect_snap("play2", 32'h0, 8'd0, 5'd1, 2'b01, 1'b0, 1'b0);
    n_row = 1'b1;
    fire = 1'b1;
    step();
    hits_exp++;
    expect_snap("col1_hit", 32'h080C_0808, 8'd1, 5'd0, 2'b01, 1'b0, 1'b1);
    fire = 1'b0;
    step();
    expect_snap("won2", 32'h080C_0808, 8'd1, 5'd0, 2'b10, 1'b0, 1'b0);

    // Two misses on column 0 with a ship remaining at cell 15.
    pulse_start();
    load(4'd15, 1'b1);
    pulse_start();
    sel = 4'b0001;
    fire = 1'b1;
    step();
    expect_snap("col0_miss1", 32'h0202_0202, 8'd1, 5'd1, 2'b01, 1'b0, 1'b0);
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    expect_snap("col0_miss2", 32'h0202_0202, 8'd2, 5'd1, 2'b01, 1'b0, 1'b0);
    fire = 1'b0;
    step();
`ifdef SHOT_LIMIT_EN
    expect_snap("lost", 32'h4202_0202, 8'd2, 5'd1, 2'b11, 1'b0, 1'b0);
    pulse_start();
    expect_snap("lost_restart", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
`else
    expect_snap("no_limit", 32'h0202_0202, 8'd2, 5'd1, 2'b01, 1'b0, 1'b0);
    step();
`endif

    // Reset mid-shot with an error flag set: everything returns at once.
    sel = 4'b0000;
    step();
    fire = 1'b1;
    reset = 1'b0;
    expect_snap("async_reset", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    step();
    fire = 1'b0; sel = 4'b0001;
    step();
    reset = 1'b1;
    step();
    expect_snap("post_reset", 32'h0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && snap_q.size() > 0; i++) step();
    check("scoreboard_drained", 32'(snap_q.size()), 32'd0);
    check("hit_pulse_count", 32'(hits_seen), 32'(hits_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
